loop_down_counter: RTL

Loadable down-counting loop controller that issues a fixed number of step requests and reports completion. It complements the datapath's loadable up counters: a controller loads an iteration count, and the block decrements it once per acknowledged step until zero. It sits between the top-level controller and the datapath unit whose steps it sequences. It provides `zero`/`borrow` flags for the controller's branch decisions.

---
 rtl/loop_down_counter.sv | 79 +++++++
 1 files changed

// File: rtl/loop_down_counter.sv
// Loadable down-counting loop controller: loads an iteration count, requests one
// datapath step per cycle in RUN and pulses done at zero. Optional abort via LOOP_DOWN_COUNTER_ABORT_EN.
module loop_down_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data,
   input  logic             step_ack,
`ifdef LOOP_DOWN_COUNTER_ABORT_EN
   input  logic             abort,
`endif
   output logic             step_req,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic             abort_hit;

`ifdef LOOP_DOWN_COUNTER_ABORT_EN
   assign abort_hit = abort && (state_reg != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               count_next = data;
               state_next = (data == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            // abort outranks step_ack and leaves the remaining count visible
            if (abort_hit) begin
               state_next = IDLE;
            end else if (step_ack) begin
               count_next = count_reg - WIDTH'(1);
               if (count_reg == WIDTH'(1))
                  state_next = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
      end
   end

   assign out      = count_reg;
   assign step_req = (state_reg == RUN);
   assign busy     = (state_reg == RUN) || (state_reg == DONE);
   assign done     = (state_reg == DONE);
   assign zero     = (count_reg == '0);
   // should never fire: RUN always holds a nonzero count
   assign borrow   = (state_reg == RUN) && step_ack && (count_reg == '0);

endmodule
